// File: rtl/led_pio_blink.sv
// Avalon-MM LED output port with atomic set/clear registers and a hardware
// blink engine whose half-period is programmable in clk cycles.
module led_pio_blink #(
  parameter int WIDTH        = 8,
  parameter int PERIOD_W     = 24,
  parameter int PERIOD_RESET = 2500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  typedef enum logic [2:0] {
    ADDR_DATA   = 3'd0,
    ADDR_SET    = 3'd1,
    ADDR_CLEAR  = 3'd2,
    ADDR_BLINK  = 3'd3,
    ADDR_PERIOD = 3'd4,
    ADDR_CTRL   = 3'd5
  } reg_addr_e;

  logic [WIDTH-1:0]    data_q, data_d;
  logic [WIDTH-1:0]    mask_q, mask_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                en_q, en_d;
  logic                phase_q, phase_d;

  logic                wr;
  logic                period_wr;
  logic                restart;
  logic [PERIOD_W-1:0] p_eff;
  logic                terminal;
  logic                unused_wd;

  assign wr        = chipselect & ~write_n;
  // A zero period behaves as one so the counter always has a reachable terminal count.
  assign p_eff     = (period_q == '0) ? PERIOD_W'(1) : period_q;
  assign terminal  = (cnt_q == p_eff - PERIOD_W'(1));
  assign unused_wd = ^writedata;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    data_d    = data_q;
    mask_d    = mask_q;
    period_d  = period_q;
    en_d      = en_q;
    period_wr = 1'b0;
    restart   = 1'b0;
    if (wr) begin
      case (address)
        ADDR_DATA:   data_d = writedata[WIDTH-1:0];
        ADDR_SET:    data_d = data_q | writedata[WIDTH-1:0];
        ADDR_CLEAR:  data_d = data_q & ~writedata[WIDTH-1:0];
        ADDR_BLINK:  mask_d = writedata[WIDTH-1:0];
        ADDR_PERIOD: begin
          period_d  = writedata[PERIOD_W-1:0];
          period_wr = 1'b1;
        end
        ADDR_CTRL: begin
          en_d    = writedata[1];
          restart = writedata[2];
        end
        default: ;
      endcase
    end

    // Disabled (now or by this write) holds the engine at the start of a high half-period;
    // the edge that enables it does not count, so the first half-period is a full P cycles.
    cnt_d   = cnt_q + PERIOD_W'(1);
    phase_d = phase_q;
    if (!en_q || !en_d || restart) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (period_wr) begin
      cnt_d   = '0;
    end else if (terminal) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= '0;
      mask_q   <= '0;
      period_q <= PERIOD_W'(PERIOD_RESET);
      cnt_q    <= '0;
      en_q     <= 1'b0;
      phase_q  <= 1'b1;
    end else begin
      data_q   <= data_d;
      mask_q   <= mask_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      phase_q  <= phase_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA, ADDR_SET, ADDR_CLEAR: readdata[WIDTH-1:0]    = data_q;
      ADDR_BLINK:                      readdata[WIDTH-1:0]    = mask_q;
      ADDR_PERIOD:                     readdata[PERIOD_W-1:0] = period_q;
      ADDR_CTRL:                       readdata[1:0]          = {en_q, phase_q};
      default: ;
    endcase
  end

  assign out_port = data_q & (~({WIDTH{en_q}} & mask_q) | {WIDTH{phase_q}});

endmodule
